// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: operation encodings and
// seven-segment constant patterns (active-low, bit order {g,f,e,d,c,b,a}).
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low seven-segment glyph, {g,f,e,d,c,b,a}, lowercase b/d.
// Only compiled when ALU_SEG_DECODE_EN is defined; the blank build has no decoder.
`ifdef ALU_SEG_DECODE_EN
module hex_to_7seg (
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    always_comb begin
        segments = 7'b1111111;
        case (nibble)
            4'h0: segments = 7'b1000000;
            4'h1: segments = 7'b1111001;
            4'h2: segments = 7'b0100100;
            4'h3: segments = 7'b0110000;
            4'h4: segments = 7'b0011001;
            4'h5: segments = 7'b0010010;
            4'h6: segments = 7'b0000010;
            4'h7: segments = 7'b1111000;
            4'h8: segments = 7'b0000000;
            4'h9: segments = 7'b0010000;
            4'hA: segments = 7'b0001000;
            4'hB: segments = 7'b0000011;
            4'hC: segments = 7'b1000110;
            4'hD: segments = 7'b0100001;
            4'hE: segments = 7'b0000110;
            default: segments = 7'b0001110;
        endcase
    end

endmodule
`endif

// File: rtl/alu.sv
// Registered 8-op ALU with zero/negative/shift-out/carry/overflow flags and
// two hex display digits; ALU_SEG_DECODE_EN enables the digit decode (else blank).
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    output logic [WIDTH-1:0] Y,
    output logic             ZRO,
    output logic             NEG,
    output logic             SO,
    output logic             CO,
    output logic             OVR,
    output logic [6:0]       Y1_SEGMENTS,
    output logic [6:0]       Y0_SEGMENTS
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] y_nxt;
    logic             so_nxt;
    logic             co_nxt;
    logic             ovr_nxt;

    always_comb begin
        sum     = '0;
        y_nxt   = '0;
        so_nxt  = 1'b0;
        co_nxt  = 1'b0;
        ovr_nxt = 1'b0;
        case (OP)
            OP_ADD: begin
                sum     = {1'b0, A} + {1'b0, B};
                y_nxt   = sum[MSB:0];
                co_nxt  = sum[WIDTH];
                ovr_nxt = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                // Bit WIDTH of the widened difference is the borrow (A < B).
                sum     = {1'b0, A} - {1'b0, B};
                y_nxt   = sum[MSB:0];
                co_nxt  = sum[WIDTH];
                ovr_nxt = (A[MSB] != B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_AND: y_nxt = A & B;
            OP_OR:  y_nxt = A | B;
            OP_XOR: y_nxt = A ^ B;
            OP_SHL: begin
                y_nxt  = {A[MSB-1:0], 1'b0};
                so_nxt = A[MSB];
            end
            OP_SHR: begin
                y_nxt  = {1'b0, A[MSB:1]};
                so_nxt = A[0];
            end
            default: y_nxt = A;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            Y   <= '0;
            ZRO <= 1'b0;
            NEG <= 1'b0;
            SO  <= 1'b0;
            CO  <= 1'b0;
            OVR <= 1'b0;
        end else begin
            Y   <= y_nxt;
            ZRO <= (y_nxt == '0);
            NEG <= y_nxt[MSB];
            SO  <= so_nxt;
            CO  <= co_nxt;
            OVR <= ovr_nxt;
        end
    end

`ifdef ALU_SEG_DECODE_EN
    hex_to_7seg u_seg_hi (
        .nibble   (Y[7:4]),
        .segments (Y1_SEGMENTS)
    );

    hex_to_7seg u_seg_lo (
        .nibble   (Y[3:0]),
        .segments (Y0_SEGMENTS)
    );
`else
    assign Y1_SEGMENTS = SEG_BLANK;
    assign Y0_SEGMENTS = SEG_BLANK;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: table of operand/op records with hand-computed
// results and flags, plus reset and mid-stream reset sequences.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] a, b;
    logic [2:0] op;
    logic [7:0] y;
    logic       zro, neg, so, co, ovr;
    logic [6:0] y1_seg, y0_seg;

    int n_vec = 0;
    int n_bad = 0;

    alu #(.WIDTH(8)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .A           (a),
        .B           (b),
        .OP          (op),
        .Y           (y),
        .ZRO         (zro),
        .NEG         (neg),
        .SO          (so),
        .CO          (co),
        .OVR         (ovr),
        .Y1_SEGMENTS (y1_seg),
        .Y0_SEGMENTS (y0_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] y;
        logic       zro, neg, so, co, ovr;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [6:0] seg_exp(input logic [3:0] n);
`ifdef ALU_SEG_DECODE_EN
        logic [6:0] glyph [16];
        glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return glyph[n];
`else
        return (n == 4'h0) ? 7'b1111111 : 7'b1111111;
`endif
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got y=%h z%b n%b s%b c%b v%b, want y=%h z%b n%b s%b c%b v%b",
                     name, act[12:5], act[4], act[3], act[2], act[1], act[0],
                     exp[12:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_seg(input string name, input logic [7:0] yexp);
        n_vec++;
        if (y1_seg !== seg_exp(yexp[7:4]) || y0_seg !== seg_exp(yexp[3:0])) begin
            n_bad++;
            $display("FAIL %s seg: got %b/%b, want %b/%b", name, y1_seg, y0_seg,
                     seg_exp(yexp[7:4]), seg_exp(yexp[3:0]));
        end
    endtask

    task automatic apply(input logic [7:0] ai, input logic [7:0] bi, input logic [2:0] opi,
                         input logic rst_ni);
        @(negedge clk);
        a = ai; b = bi; op = opi; rst_n = rst_ni;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //           name        A      B      OP      Y     z  n  s  c  v
        vecs[0]  = '{"add_d0",  8'hD0, 8'h75, 3'b000, 8'h45, 0, 0, 0, 1, 0};
        vecs[1]  = '{"sub_d0",  8'hD0, 8'h75, 3'b001, 8'h5B, 0, 0, 0, 0, 1};
        vecs[2]  = '{"and_d0",  8'hD0, 8'h75, 3'b010, 8'h50, 0, 0, 0, 0, 0};
        vecs[3]  = '{"or_d0",   8'hD0, 8'h75, 3'b011, 8'hF5, 0, 1, 0, 0, 0};
        vecs[4]  = '{"xor_d0",  8'hD0, 8'h75, 3'b100, 8'hA5, 0, 1, 0, 0, 0};
        vecs[5]  = '{"shl_d0",  8'hD0, 8'h75, 3'b101, 8'hA0, 0, 1, 1, 0, 0};
        vecs[6]  = '{"shr_d0",  8'hD0, 8'h75, 3'b110, 8'h68, 0, 0, 0, 0, 0};
        vecs[7]  = '{"add_29",  8'h29, 8'h55, 3'b000, 8'h7E, 0, 0, 0, 0, 0};
        vecs[8]  = '{"sub_29",  8'h29, 8'h55, 3'b001, 8'hD4, 0, 1, 0, 1, 0};
        vecs[9]  = '{"add_f5",  8'hF5, 8'hAB, 3'b000, 8'hA0, 0, 1, 0, 1, 0};
        vecs[10] = '{"sub_f5",  8'hF5, 8'hAB, 3'b001, 8'h4A, 0, 0, 0, 0, 0};
        vecs[11] = '{"add_ovf", 8'h7F, 8'h01, 3'b000, 8'h80, 0, 1, 0, 0, 1};
        vecs[12] = '{"sub_eq",  8'h3C, 8'h3C, 3'b001, 8'h00, 1, 0, 0, 0, 0};
        vecs[13] = '{"add_wrap",8'hFF, 8'h01, 3'b000, 8'h00, 1, 0, 0, 1, 0};
        vecs[14] = '{"pass_9c", 8'h9C, 8'h33, 3'b111, 8'h9C, 0, 1, 0, 0, 0};
        vecs[15] = '{"shr_so",  8'h81, 8'h00, 3'b110, 8'h40, 0, 0, 1, 0, 0};

        a = 8'h00; b = 8'h00; op = 3'b000; rst_n = 1'b0;

        apply(8'h12, 8'h34, 3'b000, 1'b0);
        check("reset", {y, zro, neg, so, co, ovr}, 13'h0);
`ifdef ALU_SEG_DECODE_EN
        n_vec++;
        if (y1_seg !== 7'b1000000 || y0_seg !== 7'b1000000) begin
            n_bad++;
            $display("FAIL reset seg: got %b/%b, want 1000000/1000000", y1_seg, y0_seg);
        end
`else
        check_seg("reset", 8'h00);
`endif

        foreach (vecs[i]) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
            check(vecs[i].name, {y, zro, neg, so, co, ovr},
                  {vecs[i].y, vecs[i].zro, vecs[i].neg, vecs[i].so, vecs[i].co, vecs[i].ovr});
            check_seg(vecs[i].name, vecs[i].y);
        end

        // Mid-stream reset: nonzero flags present, then reset with ADD operands live.
        apply(8'hFF, 8'h01, 3'b000, 1'b1);
        check("pre_rst", {y, zro, neg, so, co, ovr}, {8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        apply(8'hD0, 8'h75, 3'b000, 1'b0);
        check("mid_rst", {y, zro, neg, so, co, ovr}, 13'h0);
        check_seg("mid_rst", 8'h00);
        // First edge after release computes normally.
        apply(8'hD0, 8'h75, 3'b000, 1'b1);
        check("post_rst", {y, zro, neg, so, co, ovr}, {8'h45, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        check_seg("post_rst", 8'h45);

        // Back-to-back ops: each result must land exactly one edge after its inputs.
        apply(8'h7F, 8'h01, 3'b000, 1'b1);
        check("b2b_0", {y, zro, neg, so, co, ovr}, {8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        apply(8'h80, 8'h00, 3'b101, 1'b1);
        check("b2b_1", {y, zro, neg, so, co, ovr}, {8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
